cacheline_writeback_adapter: RTL and testbench



---
 rtl/cacheline_writeback_adapter_pkg.sv | 19 +
 rtl/cacheline_writeback_adapter.sv | 95 +++++++++
 tb/tb_cacheline_writeback_adapter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_writeback_adapter_pkg.sv
// Shared types and sizes for the cacheline writeback adapter, which serializes one
// dirty cacheline into a burst of memory write beats.
package cacheline_writeback_adapter_pkg;

    localparam int CACHELINE_BITS = 256;
    localparam int BMEM_BEAT_BITS = 64;
    localparam int BMEM_BURST_LEN = CACHELINE_BITS / BMEM_BEAT_BITS;

    // BURSTINGn drives beat n-1, so state[1:0] of BURSTING1..3 is the index of the next beat.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        BURSTING1 = 3'd1,
        BURSTING2 = 3'd2,
        BURSTING3 = 3'd3,
        BURSTING4 = 3'd4,
        DONE      = 3'd5
    } wb_adapter_state_t;

endpackage

// File: rtl/cacheline_writeback_adapter.sv
// Accepts one cacheline writeback from the data cache and emits it as four
// back-pressurable 64-bit write beats on the burst-memory port (Moore outputs).
module cacheline_writeback_adapter
    import cacheline_writeback_adapter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BITS  = CACHELINE_BITS,
    parameter int BEAT_BITS  = BMEM_BEAT_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_req,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [LINE_BITS-1:0]  wb_line,
    output logic                  wb_ready,
    output logic                  wb_done,
    output logic                  bmem_write,
    output logic [ADDR_WIDTH-1:0] bmem_addr,
    output logic [BEAT_BITS-1:0]  bmem_wdata,
    input  logic                  bmem_ready
);

    localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);

    wb_adapter_state_t     state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_BITS-1:0]  line_q;

    logic [ADDR_WIDTH-1:0] aligned_addr;
    logic [1:0]            next_beat;
    logic [BEAT_BITS-1:0]  next_wdata;
    logic                  unused_offset;

    assign aligned_addr  = {wb_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign unused_offset = ^wb_addr[OFFSET_BITS-1:0];
    assign next_beat     = state[1:0];
    assign next_wdata    = line_q[next_beat*BEAT_BITS +: BEAT_BITS];

    // Outputs are registered alongside the state so they depend only on flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            line_q     <= '0;
            wb_ready   <= 1'b1;
            wb_done    <= 1'b0;
            bmem_write <= 1'b0;
            bmem_addr  <= '0;
            bmem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wb_req) begin
                        state      <= BURSTING1;
                        addr_q     <= aligned_addr;
                        line_q     <= wb_line;
                        wb_ready   <= 1'b0;
                        bmem_write <= 1'b1;
                        bmem_addr  <= aligned_addr;
                        bmem_wdata <= wb_line[BEAT_BITS-1:0];
                    end
                end
                BURSTING1, BURSTING2, BURSTING3: begin
                    // A stalled beat keeps state, address and data untouched.
                    if (bmem_ready) begin
                        state      <= wb_adapter_state_t'(state + 3'd1);
                        bmem_wdata <= next_wdata;
                    end
                end
                BURSTING4: begin
                    if (bmem_ready) begin
                        state      <= DONE;
                        bmem_write <= 1'b0;
                        bmem_wdata <= '0;
                        wb_done    <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    wb_done  <= 1'b0;
                    wb_ready <= 1'b1;
                    bmem_addr <= addr_q;
                end
                default: begin
                    state      <= IDLE;
                    wb_ready   <= 1'b1;
                    wb_done    <= 1'b0;
                    bmem_write <= 1'b0;
                    bmem_wdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_writeback_adapter.sv
// Self-checking bench for cacheline_writeback_adapter: per-scenario tasks with inline
// checks plus a beat scoreboard fed from the requests the bench issues.
module tb_cacheline_writeback_adapter;

    logic         clk;
    logic         rst;
    logic         wb_req;
    logic [31:0]  wb_addr;
    logic [255:0] wb_line;
    logic         wb_ready;
    logic         wb_done;
    logic         bmem_write;
    logic [31:0]  bmem_addr;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;

    int checks;
    int failures;

    // Each entry is {line-aligned address, beat data}.
    logic [95:0] exp_q[$];

    cacheline_writeback_adapter dut (
        .clk        (clk),
        .rst        (rst),
        .wb_req     (wb_req),
        .wb_addr    (wb_addr),
        .wb_line    (wb_line),
        .wb_ready   (wb_ready),
        .wb_done    (wb_done),
        .bmem_write (bmem_write),
        .bmem_addr  (bmem_addr),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every beat the memory accepts must be the next expected one.
    always @(negedge clk) begin
        if (bmem_write === 1'b1 && bmem_ready === 1'b1 && rst === 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL beat_unexpected got %h_%h exp none", bmem_addr, bmem_wdata);
            end else begin
                logic [95:0] exp;
                exp = exp_q.pop_front();
                if ({bmem_addr, bmem_wdata} !== exp) begin
                    failures++;
                    $display("FAIL beat_data got %h_%h exp %h_%h", bmem_addr, bmem_wdata,
                             exp[95:64], exp[63:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input logic [31:0] addr, input logic [255:0] line);
        logic [31:0] aligned;
        aligned = {addr[31:5], 5'b0};
        for (int b = 0; b < 4; b++) exp_q.push_back({aligned, line[b*64 +: 64]});
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({wb_ready, wb_done, bmem_write} !== 3'b100) begin
            failures++;
            $display("FAIL reset_ctrl got rdy=%b done=%b wr=%b exp 1 0 0", wb_ready, wb_done, bmem_write);
        end
        checks++;
        if (bmem_addr !== 32'h0 || bmem_wdata !== 64'h0) begin
            failures++;
            $display("FAIL reset_data got %h %h exp 0 0", bmem_addr, bmem_wdata);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (wb_ready !== 1'b1 || bmem_write !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got rdy=%b wr=%b exp 1 0", wb_ready, bmem_write);
        end
        next_cycle();
    endtask

    task automatic test_single();
        logic [255:0] line;
        logic [63:0]  exp_beat [4];
        for (int i = 0; i < 8; i++) line[i*32 +: 32] = i;
        exp_beat[0] = 64'h00000001_00000000;
        exp_beat[1] = 64'h00000003_00000002;
        exp_beat[2] = 64'h00000005_00000004;
        exp_beat[3] = 64'h00000007_00000006;
        push_line(32'h1000_0014, line);
        for (int c = 0; c <= 6; c++) begin
            wb_req     = (c == 0);
            wb_addr    = 32'h1000_0014;
            wb_line    = line;
            bmem_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (bmem_write !== (c >= 1 && c <= 4)) begin
                failures++;
                $display("FAIL single_write c=%0d got %b", c, bmem_write);
            end
            if (c >= 1 && c <= 4) begin
                checks++;
                if (bmem_addr !== 32'h1000_0000 || bmem_wdata !== exp_beat[c-1]) begin
                    failures++;
                    $display("FAIL single_beat c=%0d got %h_%h exp 10000000_%h", c, bmem_addr,
                             bmem_wdata, exp_beat[c-1]);
                end
            end
            checks++;
            if (wb_done !== (c == 5)) begin
                failures++;
                $display("FAIL single_done c=%0d got %b", c, wb_done);
            end
            checks++;
            if (wb_ready !== (c == 0 || c == 6)) begin
                failures++;
                $display("FAIL single_ready c=%0d got %b", c, wb_ready);
            end
            next_cycle();
        end
        wb_req = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL single_drain got %0d exp 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] line;
        int           accepted;
        for (int i = 0; i < 8; i++) line[i*32 +: 32] = i;
        accepted = 0;
        push_line(32'h1000_0014, line);
        for (int c = 0; c <= 8; c++) begin
            wb_req     = (c == 0);
            wb_addr    = 32'h1000_0014;
            wb_line    = line;
            bmem_ready = !(c == 2 || c == 3);
            @(negedge clk);
            if (bmem_write === 1'b1 && bmem_ready) accepted++;
            if (c >= 2 && c <= 4) begin
                checks++;
                if (bmem_write !== 1'b1 || bmem_wdata !== 64'h00000003_00000002) begin
                    failures++;
                    $display("FAIL bp_hold c=%0d got wr=%b %h exp 1 0000000300000002", c,
                             bmem_write, bmem_wdata);
                end
            end
            checks++;
            if (wb_done !== (c == 7)) begin
                failures++;
                $display("FAIL bp_done c=%0d got %b", c, wb_done);
            end
            next_cycle();
        end
        wb_req     = 1'b0;
        bmem_ready = 1'b1;
        checks++;
        if (accepted != 4 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_count got %0d left %0d exp 4 0", accepted, exp_q.size());
        end
    endtask

    task automatic test_churn();
        logic [255:0] line_a, line_b;
        logic [31:0]  addr_a, addr_b;
        line_a = rand_line();
        line_b = rand_line();
        addr_a = 32'h2000_0047;
        addr_b = 32'h4000_01E3;
        push_line(addr_a, line_a);
        for (int c = 0; c <= 11; c++) begin
            bmem_ready = 1'b1;
            if (c == 0) begin
                wb_req = 1'b1; wb_addr = addr_a; wb_line = line_a;
            end else if (c == 6) begin
                wb_req = 1'b1; wb_addr = addr_b; wb_line = line_b;
                push_line(addr_b, line_b);
            end else begin
                wb_req  = (c < 6) ? c[0] : 1'b0;
                wb_addr = $urandom;
                wb_line = rand_line();
            end
            @(negedge clk);
            if (c >= 1 && c <= 4) begin
                checks++;
                if (bmem_write !== 1'b1 || bmem_addr !== 32'h2000_0040) begin
                    failures++;
                    $display("FAIL churn_addr_a c=%0d got wr=%b %h exp 1 20000040", c, bmem_write, bmem_addr);
                end
            end
            if (c >= 7 && c <= 10) begin
                checks++;
                if (bmem_write !== 1'b1 || bmem_addr !== 32'h4000_01E0) begin
                    failures++;
                    $display("FAIL churn_addr_b c=%0d got wr=%b %h exp 1 400001e0", c, bmem_write, bmem_addr);
                end
            end
            checks++;
            if (wb_ready !== (c == 0 || c == 6)) begin
                failures++;
                $display("FAIL churn_ready c=%0d got %b", c, wb_ready);
            end
            checks++;
            if (wb_done !== (c == 5 || c == 11)) begin
                failures++;
                $display("FAIL churn_done c=%0d got %b", c, wb_done);
            end
            next_cycle();
        end
        wb_req = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL churn_drain got %0d exp 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [255:0] line;
        line = rand_line();
        push_line(32'h5000_0020, line);
        for (int c = 0; c <= 8; c++) begin
            wb_req     = (c == 0);
            wb_addr    = 32'h5000_0020;
            wb_line    = line;
            bmem_ready = (c != 3);
            rst        = (c == 3);
            @(negedge clk);
            if (c == 3) begin
                checks++;
                if (bmem_write !== 1'b1 || bmem_wdata !== line[128 +: 64]) begin
                    failures++;
                    $display("FAIL mid_beat2 got wr=%b %h exp 1 %h", bmem_write, bmem_wdata, line[128 +: 64]);
                end
            end
            if (c >= 4) begin
                checks++;
                if ({wb_ready, wb_done, bmem_write} !== 3'b100) begin
                    failures++;
                    $display("FAIL mid_idle c=%0d got rdy=%b done=%b wr=%b exp 1 0 0", c, wb_ready,
                             wb_done, bmem_write);
                end
            end
            next_cycle();
        end
        rst = 1'b0;
        checks++;
        if (exp_q.size() != 2) begin
            failures++;
            $display("FAIL mid_accepted got left=%0d exp 2", exp_q.size());
        end
        exp_q.delete();

        for (int i = 0; i < 8; i++) line[i*32 +: 32] = 32'hDEAD_BEEF + i;
        push_line(32'h3000_007F, line);
        for (int c = 0; c <= 6; c++) begin
            wb_req     = (c == 0);
            wb_addr    = 32'h3000_007F;
            wb_line    = line;
            bmem_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (bmem_write !== (c >= 1 && c <= 4) || wb_done !== (c == 5)) begin
                failures++;
                $display("FAIL after_rst c=%0d got wr=%b done=%b", c, bmem_write, wb_done);
            end
            next_cycle();
        end
        wb_req = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL after_rst_drain got %0d exp 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] line_c, line_d;
        line_c = rand_line();
        line_d = rand_line();
        push_line(32'h6000_0000, line_c);
        push_line(32'h7000_1000, line_d);
        for (int c = 0; c <= 11; c++) begin
            wb_req     = (c <= 6);
            wb_addr    = (c == 0) ? 32'h6000_0000 : 32'h7000_1000;
            wb_line    = (c == 0) ? line_c : line_d;
            bmem_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (bmem_write !== ((c >= 1 && c <= 4) || (c >= 7 && c <= 10))) begin
                failures++;
                $display("FAIL b2b_write c=%0d got %b", c, bmem_write);
            end
            checks++;
            if (wb_done !== (c == 5 || c == 11) || wb_ready !== (c == 0 || c == 6)) begin
                failures++;
                $display("FAIL b2b_ctrl c=%0d got done=%b rdy=%b", c, wb_done, wb_ready);
            end
            next_cycle();
        end
        wb_req = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_drain got %0d exp 0", exp_q.size());
        end
    endtask

    task automatic test_random_stall();
        for (int n = 0; n < 4; n++) begin
            logic [255:0] line;
            logic [31:0]  addr;
            int           accepted;
            bit           exp_done;
            bit           seen_done;
            line      = rand_line();
            addr      = $urandom;
            accepted  = 0;
            exp_done  = 1'b0;
            seen_done = 1'b0;
            push_line(addr, line);
            for (int c = 0; c < 60 && !seen_done; c++) begin
                wb_req     = (c == 0);
                wb_addr    = addr;
                wb_line    = line;
                bmem_ready = ($urandom_range(0, 2) != 0);
                @(negedge clk);
                checks++;
                if (wb_done !== exp_done) begin
                    failures++;
                    $display("FAIL rand_done n=%0d c=%0d got %b exp %b", n, c, wb_done, exp_done);
                end
                seen_done = exp_done;
                exp_done  = 1'b0;
                if (bmem_write === 1'b1 && bmem_ready) begin
                    accepted++;
                    if (accepted == 4) exp_done = 1'b1;
                end
                next_cycle();
            end
            wb_req     = 1'b0;
            bmem_ready = 1'b1;
            checks++;
            if (!seen_done || accepted != 4) begin
                failures++;
                $display("FAIL rand_burst n=%0d got done=%b beats=%0d exp 1 4", n, seen_done, accepted);
            end
            next_cycle();
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rand_drain got %0d exp 0", exp_q.size());
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        wb_req     = 1'b0;
        wb_addr    = '0;
        wb_line    = '0;
        bmem_ready = 1'b1;
        test_reset();
        test_single();
        test_backpressure();
        test_churn();
        test_reset_mid_burst();
        test_back_to_back();
        test_random_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
